// File: rtl/cordic_sched.sv
// -----------------------------------------------------------------------------
// cordic_sched
//
// Shares one iterative CORDIC rotation core between two angle requesters.
// A request accepted in IDLE is loaded into the core (LOAD), then the core
// is stepped through ITERS micro-rotations (RUN). The result is then offered
// downstream with the owning requester's tag (DONE) until it is consumed.
//
// Build option:
//   CORDIC_SCHED_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                               undefined -> round-robin between requesters
//
// Ports:
//   clk_i         single clock, rising edge
//   rst_i         synchronous active-high reset
//   req0_valid_i  requester 0 has an angle pending
//   req0_angle_i  requester 0 angle (two's complement)
//   req0_ready_o  requester 0 accepted this cycle (combinational)
//   req1_valid_i  requester 1 has an angle pending
//   req1_angle_i  requester 1 angle (two's complement)
//   req1_ready_o  requester 1 accepted this cycle (combinational)
//   core_load_o   one-cycle pulse loading the core with core_angle_o
//   core_angle_o  captured angle of the current operation
//   core_step_o   core performs one micro-rotation this cycle
//   core_iter_o   index of the current micro-rotation (0 outside RUN)
//   res_valid_o   core result valid
//   res_tag_o     requester owning the result
//   res_ready_i   downstream consumes the result
// -----------------------------------------------------------------------------
module cordic_sched #(
    parameter int ITERS  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_angle_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_angle_i,
    output logic              req1_ready_o,
    output logic              core_load_o,
    output logic [DATA_W-1:0] core_angle_o,
    output logic              core_step_o,
    output logic [IDX_W-1:0]  core_iter_o,
    output logic              res_valid_o,
    output logic              res_tag_o,
    input  logic              res_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERS - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] angle_q, angle_d;
    logic              tag_q, tag_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              load_q, load_d;
    logic              step_q, step_d;
    logic              valid_q, valid_d;

    logic              grant_s;
    logic              grant_valid_s;
    logic              accept_s;

`ifdef CORDIC_SCHED_FIXED_PRIO_EN
    // Fixed-priority arbiter: requester 1 only wins when requester 0 is idle.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid_i) begin
            grant_s = 1'b0;
        end else if (req1_valid_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end
`else
    logic rr_q, rr_d;

    // Round-robin arbiter: on contention, grant the requester not served last.
    always_comb begin
        grant_s = rr_q;
        if (req0_valid_i && req1_valid_i) begin
            grant_s = ~rr_q;
        end else if (req0_valid_i) begin
            grant_s = 1'b0;
        end else if (req1_valid_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = rr_q;
        end
    end

    // The pointer only moves on a real handshake.
    always_comb begin
        rr_d = rr_q;
        if (accept_s) begin
            rr_d = grant_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register; reset to 1 so requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Handshake qualification; readies are suppressed while reset is held.
    always_comb begin
        grant_valid_s = grant_s ? req1_valid_i : req0_valid_i;
        accept_s      = (state_q == ST_IDLE) && !rst_i && grant_valid_s;
        req0_ready_o  = accept_s && (grant_s == 1'b0);
        req1_ready_o  = accept_s && (grant_s == 1'b1);
    end

    // Next-state, capture and counter logic.
    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept_s) begin
                    angle_d = grant_s ? req1_angle_i : req0_angle_i;
                    tag_d   = grant_s;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Counter returns to 0 on the last step so core_iter_o reads 0 in DONE.
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flags are decoded from the next state so they leave flops directly.
    always_comb begin
        load_d  = (state_d == ST_LOAD);
        step_d  = (state_d == ST_RUN);
        valid_d = (state_d == ST_DONE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            angle_q <= '0;
            tag_q   <= 1'b0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            step_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            step_q  <= step_d;
            valid_q <= valid_d;
        end
    end

    assign core_load_o  = load_q;
    assign core_angle_o = angle_q;
    assign core_step_o  = step_q;
    assign core_iter_o  = cnt_q;
    assign res_valid_o  = valid_q;
    assign res_tag_o    = tag_q;

endmodule

// File: tb/tb_cordic_sched.sv
// -----------------------------------------------------------------------------
// tb_cordic_sched
//
// Directed bench for cordic_sched with ITERS=16. Inputs change and outputs
// are sampled 1-2 time units after the rising edge (clock period 10).
// Define CORDIC_SCHED_FIXED_PRIO_EN for both files to check the fixed build.
// -----------------------------------------------------------------------------
module tb_cordic_sched;

    localparam int ITERS  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_angle_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_angle_i;
    logic              req1_ready_o;
    logic              core_load_o;
    logic [DATA_W-1:0] core_angle_o;
    logic              core_step_o;
    logic [IDX_W-1:0]  core_iter_o;
    logic              res_valid_o;
    logic              res_tag_o;
    logic              res_ready_i;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    cordic_sched #(.ITERS(ITERS), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_angle_i (req0_angle_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_angle_i (req1_angle_i),
        .req1_ready_o (req1_ready_o),
        .core_load_o  (core_load_o),
        .core_angle_o (core_angle_o),
        .core_step_o  (core_step_o),
        .core_iter_o  (core_iter_o),
        .res_valid_o  (res_valid_o),
        .res_tag_o    (res_tag_o),
        .res_ready_i  (res_ready_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cycle++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        res_ready_i  = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        settle();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(req0_ready_o || req1_ready_o) && n < 40) begin
            tick();
            n++;
        end
        check("wait_ready", {31'd0, req0_ready_o | req1_ready_o}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid_o && n < 40) begin
            tick();
            n++;
        end
        check("wait_valid", {31'd0, res_valid_o}, 32'd1);
    endtask

    initial begin
        int acc_cycle;
        int prev_acc;
        int exp_grant;
        int seen_valid;
        int seen_r1;
        req0_angle_i = 16'h0000;
        req1_angle_i = 16'h0000;

        // ---------------- reset state, then single request ----------------
        do_reset();
        check("rst_load",  {31'd0, core_load_o}, 32'd0);
        check("rst_step",  {31'd0, core_step_o}, 32'd0);
        check("rst_iter",  {28'd0, core_iter_o}, 32'd0);
        check("rst_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_tag",   {31'd0, res_tag_o},   32'd0);
        check("rst_angle", {16'd0, core_angle_o}, 32'd0);
        check("rst_rdy0",  {31'd0, req0_ready_o}, 32'd0);

        req0_valid_i = 1'b1;
        req0_angle_i = 16'h2000;
        settle();
        check("single_rdy0", {31'd0, req0_ready_o}, 32'd1);
        check("single_rdy1", {31'd0, req1_ready_o}, 32'd0);
        tick();
        req0_valid_i = 1'b0;
        settle();
        check("single_load",  {31'd0, core_load_o}, 32'd1);
        check("single_angle", {16'd0, core_angle_o}, 32'h2000);
        check("single_nostep", {31'd0, core_step_o}, 32'd0);
        for (int i = 0; i < ITERS; i++) begin
            tick();
            check("single_step", {31'd0, core_step_o}, 32'd1);
            check("single_iter", {28'd0, core_iter_o}, i);
            check("single_noload", {31'd0, core_load_o}, 32'd0);
        end
        tick();
        check("single_valid", {31'd0, res_valid_o}, 32'd1);
        check("single_tag",   {31'd0, res_tag_o},   32'd0);
        check("single_step_off", {31'd0, core_step_o}, 32'd0);
        check("single_iter_off", {28'd0, core_iter_o}, 32'd0);
        tick();
        check("single_idle", {31'd0, res_valid_o}, 32'd0);
        check("single_hold_angle", {16'd0, core_angle_o}, 32'h2000);

        // ---------------- contention, both valid ----------------
        do_reset();
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_angle_i = 16'h1111;
        req1_angle_i = 16'hE222;
        settle();
        prev_acc = 0;
        seen_r1  = 0;
        for (int op = 0; op < 4; op++) begin
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
            exp_grant = 0;
`else
            exp_grant = op % 2;
`endif
            wait_ready();
            if (req1_ready_o) seen_r1++;
            acc_cycle = cycle;
            check("cont_rdy0", {31'd0, req0_ready_o}, (exp_grant == 0) ? 32'd1 : 32'd0);
            check("cont_rdy1", {31'd0, req1_ready_o}, (exp_grant == 1) ? 32'd1 : 32'd0);
            if (op > 0) check("cont_spacing", acc_cycle - prev_acc, 32'd19);
            prev_acc = acc_cycle;
            tick();
            check("cont_angle", {16'd0, core_angle_o}, (exp_grant == 1) ? 32'hE222 : 32'h1111);
            wait_valid();
            check("cont_tag", {31'd0, res_tag_o}, exp_grant);
            tick();
        end
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
        check("fixed_no_rdy1", seen_r1, 32'd0);
`endif

        // ---------------- backpressure ----------------
        do_reset();
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        req0_angle_i = 16'h0123;
        req1_angle_i = 16'h0456;
        res_ready_i  = 1'b0;
        settle();
        wait_ready();
        check("bp_rdy0", {31'd0, req0_ready_o}, 32'd1);
        tick();
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, res_valid_o}, 32'd1);
            check("bp_tag",   {31'd0, res_tag_o},   32'd0);
            check("bp_rdy0",  {31'd0, req0_ready_o}, 32'd0);
            check("bp_rdy1",  {31'd0, req1_ready_o}, 32'd0);
        end
        res_ready_i = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, res_valid_o}, 32'd0);
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
        check("bp_release_rdy0", {31'd0, req0_ready_o}, 32'd1);
`else
        check("bp_release_rdy1", {31'd0, req1_ready_o}, 32'd1);
`endif
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        settle();

        // ---------------- reset mid-RUN ----------------
        do_reset();
        req0_valid_i = 1'b1;
        req0_angle_i = 16'h0ABC;
        settle();
        wait_ready();
        tick();
        req0_valid_i = 1'b0;
        begin
            int n = 0;
            while (!(core_step_o && core_iter_o == 4'd7) && n < 40) begin
                tick();
                n++;
            end
        end
        check("mid_iter7", {28'd0, core_iter_o}, 32'd7);
        rst_i = 1'b1;
        tick();
        check("mid_load",  {31'd0, core_load_o}, 32'd0);
        check("mid_step",  {31'd0, core_step_o}, 32'd0);
        check("mid_iter",  {28'd0, core_iter_o}, 32'd0);
        check("mid_valid", {31'd0, res_valid_o}, 32'd0);
        check("mid_angle", {16'd0, core_angle_o}, 32'd0);
        check("mid_rdy0",  {31'd0, req0_ready_o}, 32'd0);
        rst_i = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid_o || core_step_o) seen_valid++;
        end
        check("mid_no_result", seen_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
